// File: rtl/fir_delay_line_ctrl_if.sv
// Bus bundle for one FIR lane delay-line controller: sample input, BRAM port pair and tap stream.
interface fir_delay_line_ctrl_if #(
   parameter int unsigned AddrWidth   = 10,
   parameter int unsigned DataSize    = 16,
   parameter int unsigned NumTaps     = 64,
   parameter int unsigned TapIdxWidth = $clog2(NumTaps)
);
   logic                   s_valid_i;
   logic                   s_ready_o;
   logic [DataSize-1:0]    s_data_i;

   logic                   bram_wvalid_o;
   logic [DataSize-1:0]    bram_wdata_o;
   logic [AddrWidth-1:0]   bram_waddr_o;
   logic [AddrWidth-1:0]   bram_raddr_o;
   logic [DataSize-1:0]    bram_rdata_i;

   logic                   tap_valid_o;
   logic [DataSize-1:0]    tap_data_o;
   logic [TapIdxWidth-1:0] tap_idx_o;
   logic                   tap_last_o;
   logic                   busy_o;

   // Controller side
   modport slave (
      input  s_valid_i, s_data_i, bram_rdata_i,
      output s_ready_o, bram_wvalid_o, bram_wdata_o, bram_waddr_o, bram_raddr_o,
             tap_valid_o, tap_data_o, tap_idx_o, tap_last_o, busy_o
   );

   // Environment side: sample source, BRAM and MAC stage
   modport master (
      output s_valid_i, s_data_i, bram_rdata_i,
      input  s_ready_o, bram_wvalid_o, bram_wdata_o, bram_waddr_o, bram_raddr_o,
             tap_valid_o, tap_data_o, tap_idx_o, tap_last_o, busy_o
   );
endinterface

// File: rtl/fir_delay_line_ctrl.sv
// FIR lane delay-line controller: writes samples into a circular BRAM buffer and
// streams back the newest NumTaps samples, newest first, masking taps not yet filled.
module fir_delay_line_ctrl #(
   parameter int unsigned AddrWidth   = 10,
   parameter int unsigned DataSize    = 16,
   parameter int unsigned NumTaps     = 64,
   parameter int unsigned TapIdxWidth = $clog2(NumTaps)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   fir_delay_line_ctrl_if.slave  bus
);

   localparam int unsigned FillWidth = $clog2(NumTaps + 1);
   localparam logic [TapIdxWidth-1:0] LastIdx = TapIdxWidth'(NumTaps - 1);
   localparam logic [FillWidth-1:0]   FillMax = FillWidth'(NumTaps);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      READ = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [AddrWidth-1:0]   wptr_q,  wptr_d;
   logic [AddrWidth-1:0]   base_q,  base_d;
   logic [TapIdxWidth-1:0] k_q,     k_d;
   logic [FillWidth-1:0]   fill_q,  fill_d;
   logic                   issue_q, issue_d;
   logic [TapIdxWidth-1:0] idx_q,   idx_d;
   logic                   mask_q,  mask_d;

   logic ready_c;
   logic handshake_c;

   assign ready_c     = (state_q == IDLE) && !clear_i;
   assign handshake_c = bus.s_valid_i && ready_c;

   // State and tap-issue registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         base_q  <= '0;
         k_q     <= '0;
         fill_q  <= '0;
         issue_q <= 1'b0;
         idx_q   <= '0;
         mask_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         base_q  <= base_d;
         k_q     <= k_d;
         fill_q  <= fill_d;
         issue_q <= issue_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
      end
   end

   // Next-state: clear wins over a same-cycle handshake and leaves BRAM untouched
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      base_d  = base_q;
      k_d     = k_q;
      fill_d  = fill_q;
      issue_d = 1'b0;
      idx_d   = '0;
      mask_d  = 1'b0;

      if (clear_i) begin
         state_d = IDLE;
         wptr_d  = '0;
         base_d  = '0;
         k_d     = '0;
         fill_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (handshake_c) begin
                  base_d  = wptr_q;
                  wptr_d  = wptr_q + AddrWidth'(1);
                  k_d     = '0;
                  state_d = READ;
                  if (fill_q != FillMax) begin
                     fill_d = fill_q + FillWidth'(1);
                  end
               end
            end
            READ: begin
               issue_d = 1'b1;
               idx_d   = k_q;
               // Older than anything received since reset/clear: emit zero instead of stale BRAM data
               mask_d  = (FillWidth'(k_q) >= fill_q);
               if (k_q == LastIdx) begin
                  k_d     = '0;
                  state_d = IDLE;
               end else begin
                  k_d     = k_q + TapIdxWidth'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign bus.s_ready_o     = ready_c;

   assign bus.bram_wvalid_o = handshake_c;
   assign bus.bram_wdata_o  = bus.s_data_i;
   assign bus.bram_waddr_o  = wptr_q;
   // Walk backwards from the newest sample; unsigned subtraction wraps below address 0
   assign bus.bram_raddr_o  = (state_q == READ) ? (base_q - AddrWidth'(k_q)) : base_q;

   assign bus.tap_valid_o   = issue_q;
   assign bus.tap_idx_o     = idx_q;
   assign bus.tap_data_o    = (issue_q && !mask_q) ? bus.bram_rdata_i : '0;
   assign bus.tap_last_o    = issue_q && (idx_q == LastIdx);
   assign bus.busy_o        = (state_q == READ) || issue_q;

endmodule

// File: tb/tb_fir_delay_line_ctrl.sv
// Directed bench for fir_delay_line_ctrl with a sample-history reference model and a BRAM model.
module tb_fir_delay_line_ctrl;
   localparam int unsigned AW = 3;
   localparam int unsigned DW = 16;
   localparam int unsigned NT = 4;
   localparam int AMask = (1 << AW) - 1;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic clear_i;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   fir_delay_line_ctrl_if #(.AddrWidth(AW), .DataSize(DW), .NumTaps(NT)) bus ();

   fir_delay_line_ctrl #(.AddrWidth(AW), .DataSize(DW), .NumTaps(NT)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .bus     (bus.slave)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Dual-port BRAM with registered read data
   logic [DW-1:0] mem [1 << AW];
   always @(posedge clk_i) begin
      if (bus.bram_wvalid_o) mem[bus.bram_waddr_o] <= bus.bram_wdata_o;
      bus.bram_rdata_i <= mem[bus.bram_raddr_o];
   end

   typedef struct { int due; int data; int idx; } sched_t;
   typedef struct { int cyc; int data; int idx; bit last; } obs_t;

   sched_t sched[$];
   obs_t   obs[$];
   int     hist[$];
   int     wlog[$];
   int     hslog[$];
   int     wcount   = 0;
   int     last_hs  = 0;
   int     last_wa  = 0;
   int     read_end = 0;
   bit     has_hs   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_flush();
      sched.delete();
      hist.delete();
      wcount   = 0;
      has_hs   = 1'b0;
      read_end = 0;
   endtask

   // Reference model and per-cycle compare
   always @(negedge clk_i) begin
      bit     exp_ready, hs, exp_valid, exp_last, exp_busy;
      int     exp_data, exp_idx, d;
      sched_t s;
      if (!rst_ni) begin
         model_flush();
         chk("rst_tap_valid", int'(bus.tap_valid_o), 0);
         chk("rst_tap_data", int'(bus.tap_data_o), 0);
         chk("rst_tap_idx", int'(bus.tap_idx_o), 0);
         chk("rst_tap_last", int'(bus.tap_last_o), 0);
         chk("rst_busy", int'(bus.busy_o), 0);
         chk("rst_wvalid", int'(bus.bram_wvalid_o), 0);
      end else begin
         exp_ready = (cyc >= read_end) && !clear_i;
         hs        = bus.s_valid_i && exp_ready;
         exp_valid = 1'b0;
         exp_data  = 0;
         exp_idx   = 0;
         exp_last  = 1'b0;
         if (sched.size() > 0 && sched[0].due == cyc) begin
            s         = sched.pop_front();
            exp_valid = 1'b1;
            exp_data  = s.data;
            exp_idx   = s.idx;
            exp_last  = (s.idx == NT - 1);
         end
         exp_busy = has_hs && (cyc > last_hs) && (cyc <= read_end);

         chk("s_ready", int'(bus.s_ready_o), int'(exp_ready));
         chk("bram_wvalid", int'(bus.bram_wvalid_o), int'(hs));
         if (hs) begin
            chk("bram_waddr", int'(bus.bram_waddr_o), wcount & AMask);
            chk("bram_wdata", int'(bus.bram_wdata_o), int'(bus.s_data_i));
         end
         chk("tap_valid", int'(bus.tap_valid_o), int'(exp_valid));
         chk("tap_data", int'(bus.tap_data_o), exp_data);
         chk("tap_last", int'(bus.tap_last_o), int'(exp_last));
         chk("busy", int'(bus.busy_o), int'(exp_busy));
         if (exp_valid) chk("tap_idx", int'(bus.tap_idx_o), exp_idx);
         if (has_hs && cyc > last_hs && cyc <= last_hs + NT)
            chk("bram_raddr", int'(bus.bram_raddr_o), (last_wa - (cyc - last_hs - 1)) & AMask);

         if (bus.tap_valid_o)
            obs.push_back('{cyc, int'(bus.tap_data_o), int'(bus.tap_idx_o), bus.tap_last_o});
         if (bus.bram_wvalid_o) wlog.push_back(int'(bus.bram_waddr_o));

         if (clear_i) begin
            model_flush();
         end else if (hs) begin
            hist.push_back(int'(bus.s_data_i));
            if (hist.size() > NT) void'(hist.pop_front());
            for (int i = 0; i < NT; i++) begin
               d = (i < hist.size()) ? hist[hist.size() - 1 - i] : 0;
               sched.push_back('{cyc + 2 + i, d, i});
            end
            last_wa  = wcount & AMask;
            wcount++;
            has_hs   = 1'b1;
            last_hs  = cyc;
            read_end = cyc + NT + 1;
            hslog.push_back(cyc);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic reset_dut();
      rst_ni = 1'b0;
      idle(2);
      rst_ni = 1'b1;
   endtask

   // Returns in the cycle after the handshake, 1 time unit past the edge
   task automatic push(input int v, output int t);
      bit done;
      done = 1'b0;
      t    = -1;
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = DW'(v);
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk_i);
         if (bus.s_ready_o) begin
            done = 1'b1;
            t    = cyc;
         end
         @(posedge clk_i);
         #1;
      end
      bus.s_valid_i = 1'b0;
      bus.s_data_i  = 16'hDEAD;
      if (!done) chk("push_timeout", 0, 1);
   endtask

   task automatic chk_taps(input string name, input int at,
                           input int e0, input int e1, input int e2, input int e3);
      int e [4];
      e = '{e0, e1, e2, e3};
      if (obs.size() < at + 4) begin
         chk({name, "_count"}, obs.size(), at + 4);
      end else begin
         for (int i = 0; i < 4; i++) begin
            chk({name, "_data"}, obs[at + i].data, e[i]);
            chk({name, "_idx"}, obs[at + i].idx, i);
         end
      end
   endtask

   initial begin
      int t;
      int n;
      bit hsnow;
      int r [4];
      int wexp [10];
      wexp = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

      rst_ni        = 1'b1;
      clear_i       = 1'b0;
      bus.s_valid_i = 1'b0;
      bus.s_data_i  = '0;
      #1 reset_dut();

      // Single sample after reset
      obs.delete(); wlog.delete();
      push(16'h0011, t);
      idle(6);
      chk_taps("t1", 0, 'h11, 0, 0, 0);
      if (obs.size() >= 4) begin
         chk("t1_first_latency", obs[0].cyc - t, 2);
         chk("t1_last_latency", obs[3].cyc - t, 5);
         chk("t1_last_flag", int'(obs[3].last), 1);
         chk("t1_idx0_not_last", int'(obs[0].last), 0);
      end
      chk("t1_writes", wlog.size(), 1);
      if (wlog.size() >= 1) chk("t1_waddr", wlog[0], 0);

      // Fill-up masking
      reset_dut();
      obs.delete(); wlog.delete();
      for (int v = 1; v <= 5; v++) push(v, t);
      idle(6);
      chk("t2_tap_count", obs.size(), 20);
      chk_taps("t2_s2", 4, 2, 1, 0, 0);
      chk_taps("t2_s5", 16, 5, 4, 3, 2);

      // Address wrap
      reset_dut();
      obs.delete(); wlog.delete();
      for (int v = 1; v <= 9; v++) push(v, t);
      push(10, t);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         r[k] = int'(bus.bram_raddr_o);
         @(posedge clk_i);
         #1;
      end
      idle(2);
      chk("t3_raddr0", r[0], 1);
      chk("t3_raddr1", r[1], 0);
      chk("t3_raddr2", r[2], 7);
      chk("t3_raddr3", r[3], 6);
      chk("t3_writes", wlog.size(), 10);
      if (wlog.size() >= 10)
         for (int i = 0; i < 10; i++) chk("t3_waddr", wlog[i], wexp[i]);
      chk_taps("t3_s10", 36, 10, 9, 8, 7);

      // Back-to-back throughput with s_valid held high
      reset_dut();
      obs.delete(); wlog.delete(); hslog.delete();
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = 16'd100;
      n = 0;
      for (int i = 0; i < 80 && n < 6; i++) begin
         @(negedge clk_i);
         hsnow = bus.s_ready_o;
         @(posedge clk_i);
         #1;
         if (hsnow) begin
            n++;
            bus.s_data_i = DW'(100 + n);
         end
      end
      bus.s_valid_i = 1'b0;
      chk("t4_handshakes", n, 6);
      idle(6);
      chk("t4_hslog", hslog.size(), 6);
      if (hslog.size() >= 6)
         for (int j = 1; j < 6; j++) chk("t4_hs_gap", hslog[j] - hslog[j-1], 5);
      chk("t4_writes", wlog.size(), 6);
      chk("t4_taps", obs.size(), 24);
      if (obs.size() >= 24) begin
         for (int j = 0; j < 6; j++) chk("t4_newest", obs[4*j].data, 100 + j);
         for (int m = 1; m < 24; m++)
            chk("t4_tap_spacing", obs[m].cyc - obs[m-1].cyc, (m % 4 == 0) ? 2 : 1);
      end

      // Async reset mid-read, then stale BRAM must stay masked
      reset_dut();
      obs.delete(); wlog.delete();
      for (int v = 1; v <= 5; v++) push(v, t);
      idle(2);
      @(negedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      idle(2);
      rst_ni = 1'b1;
      idle(6);
      chk("t5_partial_taps", obs.size(), 18);
      if (obs.size() >= 18) begin
         chk("t5_last_idx", obs[17].idx, 1);
         chk("t5_no_last", int'(obs[17].last), 0);
      end
      obs.delete(); wlog.delete();
      push(16'h00AA, t);
      idle(6);
      chk_taps("t5_aa", 0, 'hAA, 0, 0, 0);
      if (wlog.size() >= 1) chk("t5_waddr", wlog[0], 0);

      // Clear coincident with a valid sample
      obs.delete(); wlog.delete();
      clear_i       = 1'b1;
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = 16'h0055;
      idle(1);
      clear_i       = 1'b0;
      bus.s_valid_i = 1'b0;
      idle(4);
      chk("t6_no_write", wlog.size(), 0);
      chk("t6_no_taps", obs.size(), 0);
      push(16'h0007, t);
      idle(6);
      chk("t6_writes", wlog.size(), 1);
      if (wlog.size() >= 1) chk("t6_waddr", wlog[0], 0);
      chk_taps("t6", 0, 7, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_delay_line_ctrl.md
Name: fir_delay_line_ctrl

Overview:
- Controls the sample delay line of one FIR lane. It sits directly upstream of the lane's dual-port block RAM.
- Accepts input samples over a valid/ready handshake and writes each one into the BRAM as a circular buffer.
- After each write it reads back the newest NumTaps samples, newest first, and presents them as an indexed tap stream to the downstream MAC stage.

Parameters:
- AddrWidth, 10, BRAM address width; circular buffer depth is 2**AddrWidth.
- DataSize, 16, sample width in bits; matches the BRAM word size.
- NumTaps, 64, taps read per sample; legal range 2 to 2**AddrWidth.
- TapIdxWidth, $clog2(NumTaps), derived; width of the tap index.

Ports:
- clk_i  input  1  clock; all logic on its rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- clear_i  input  1  synchronous flush; same effect as reset, but leaves BRAM contents unchanged.
- s_valid_i  input  1  input sample valid.
- s_ready_o  output  1  block can accept a sample.
- s_data_i  input  DataSize  input sample.
- bram_wvalid_o  output  1  BRAM write enable.
- bram_wdata_o  output  DataSize  BRAM write data.
- bram_waddr_o  output  AddrWidth  BRAM write address.
- bram_raddr_o  output  AddrWidth  BRAM read address.
- bram_rdata_i  input  DataSize  BRAM read data, registered inside BRAM, 1-cycle latency.
- tap_valid_o  output  1  tap output valid.
- tap_data_o  output  DataSize  tap sample (0 if not yet filled).
- tap_idx_o  output  TapIdxWidth  tap index; 0 is the newest sample.
- tap_last_o  output  1  high with the tap where idx = NumTaps-1.
- busy_o  output  1  high in READ state or while a tap output is pending.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, wptr=0, base=0, k=0, fill=0.
  - tap_valid_o=0, tap_idx_o=0, tap_last_o=0, busy_o=0.
  - bram_wvalid_o=0.
  - s_ready_o=1 from the first cycle after reset release.
- clear_i=1: same register values as reset, applied synchronously at the next edge. clear_i has priority over a handshake in the same cycle. s_ready_o=0 while clear_i=1.
- s_ready_o = (state==IDLE) && !clear_i, combinational.
- IDLE, handshake (s_valid_i && s_ready_o) in cycle T:
  - Combinational write in T: bram_wvalid_o=1, bram_wdata_o=s_data_i, bram_waddr_o=wptr.
  - At the edge: base<=wptr; wptr<=wptr+1 mod 2**AddrWidth; fill<=min(fill+1, NumTaps); k<=0; state<=READ.
- bram_wvalid_o=0 in every other cycle. s_data_i is ignored when there is no handshake.
- READ (cycles T+1 .. T+NumTaps):
  - bram_raddr_o = (base - k) mod 2**AddrWidth; natural wrap below address 0.
  - Each cycle: k<=k+1. Register issue=1, idx=k, and mask=(k>=fill) for the next cycle.
  - When k==NumTaps-1: state<=IDLE.
- In IDLE with no transaction, bram_raddr_o=base; the value is don't-care.
- Tap output, one cycle after issue:
  - tap_valid_o=issue_q, tap_idx_o=idx_q.
  - tap_data_o = mask_q ? 0 : bram_rdata_i, combinational passthrough.
  - tap_last_o = issue_q && idx_q==NumTaps-1.
  - When tap_valid_o=0, tap_data_o must read as 0.
- Latency: tap idx0 appears at T+2 and the last tap at T+NumTaps+1. Downstream has no backpressure and must accept one tap per cycle.
- Throughput:
  - The block returns to IDLE at T+NumTaps+1, so the next handshake is possible in that cycle, concurrent with the last tap output.
  - Maximum rate is one sample per NumTaps+1 cycles.
- Read-after-write: the write commits at the T edge and the first read is issued at T+1, so the newest sample is always returned. No same-address read/write collision occurs.
- fill masking: BRAM contents from before the reset or clear never appear at the output. Taps older than the number of samples received read as 0 until NumTaps samples have arrived.
- Reset or clear mid-READ: the READ sequence is aborted. tap_valid_o=0 from the next cycle, or immediately for async reset. No tap_last_o is produced.

Test Plan:
(Bench configuration: NumTaps=4, AddrWidth=3, DataSize=16.)
1. Reset, push 0x0011 at T → waddr 0, wvalid at T only; taps at T+2..T+5 = (idx0 0x0011, idx1 0, idx2 0, idx3 0); tap_last_o only at T+5; s_ready_o=0 during T+1..T+4, 1 at T+5.
2. Push 1,2,3,4,5 → taps for sample 5 = 5,4,3,2; taps for sample 2 = 2,1,0,0.
3. Wrap: push 1..10 → waddr sequence 0..7,0,1; taps for sample 10 = 10,9,8,7, with raddr sequence 1,0,7,6.
4. Hold s_valid_i=1 with a new value each handshake → handshakes exactly every 5 cycles; each sample written once; no tap gaps or overlaps.
5. Assert rst_ni=0 after tap idx1 of sample 5 → tap_valid_o drops immediately; after release, push 0x00AA → taps 0xAA,0,0,0. BRAM holds stale data, so this checks the masking.
6. clear_i=1 for one cycle coincident with s_valid_i=1 → no write, no taps; next push 0x0007 → waddr 0, taps 7,0,0,0.
